// File: rtl/qu_issue_sched.sv
// qu_issue_sched -- oldest-first issue scheduler for the Qu reservation station.
//
// Tracks allocation order of reservation-station entries in an age matrix,
// picks the oldest entries whose operands are ready, and presents their
// addresses on registered valid/ready issue ports. Accepted entries are
// strobed back to the reservation station for deallocation.
//
// Build option: define QU_ISSUE_SCHED_DUAL_EN for two issue ports. Without it,
// port 1 is compiled out (outputs tied low, issue1_ready ignored) and only the
// oldest eligible entry is selected each cycle.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 drop all pending and held entries at the next edge
//   stall                 block new selections; held ports keep their contents
//   alloc_en, alloc_addr  rename writes entry alloc_addr this cycle
//   rs_ready              per-entry "all operands ready"
//   issue0_valid/addr/ready  port 0 handshake (older entry)
//   issue1_valid/addr/ready  port 1 handshake
//   free0_en/addr, free1_en/addr  combinational deallocate strobes
//   pending_cnt           number of allocated entries not yet loaded into a port

module qu_issue_sched_chk #(
  parameter int RS_DEPTH      = 16,
  parameter int RS_ADDR_WIDTH = $clog2(RS_DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     alloc_en_i,
  input  logic [RS_ADDR_WIDTH-1:0] alloc_addr_i,
  input  logic [RS_DEPTH-1:0]      pending_i,
  input  logic [RS_DEPTH-1:0]      held_i
);

  // An allocation must target an entry that is neither pending nor in a port.
  a_alloc_free: assert property (@(posedge clk_i) disable iff (rst_i)
      alloc_en_i |-> !(pending_i[alloc_addr_i] || held_i[alloc_addr_i]))
    else $error("qu_issue_sched: alloc_en to busy entry %0d", alloc_addr_i);

endmodule

module qu_issue_sched #(
  parameter int RS_DEPTH      = 16,
  parameter int RS_ADDR_WIDTH = $clog2(RS_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     stall,
  input  logic                     alloc_en,
  input  logic [RS_ADDR_WIDTH-1:0] alloc_addr,
  input  logic [RS_DEPTH-1:0]      rs_ready,
  output logic                     issue0_valid,
  output logic [RS_ADDR_WIDTH-1:0] issue0_addr,
  input  logic                     issue0_ready,
  output logic                     issue1_valid,
  output logic [RS_ADDR_WIDTH-1:0] issue1_addr,
  input  logic                     issue1_ready,
  output logic                     free0_en,
  output logic [RS_ADDR_WIDTH-1:0] free0_addr,
  output logic                     free1_en,
  output logic [RS_ADDR_WIDTH-1:0] free1_addr,
  output logic [RS_ADDR_WIDTH:0]   pending_cnt
);

  // Row i of age holds bit j set when entry j is older than entry i.
  // An entry is the oldest candidate when no other candidate is older.
  function automatic logic [RS_DEPTH-1:0] oldest_oh(
    input logic [RS_DEPTH-1:0]               cand,
    input logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age
  );
    logic [RS_DEPTH-1:0] oh;
    for (int i = 0; i < RS_DEPTH; i++) begin
      oh[i] = cand[i] & ~(|(age[i] & cand));
    end
    return oh;
  endfunction

  function automatic logic [RS_ADDR_WIDTH-1:0] oh_encode(input logic [RS_DEPTH-1:0] oh);
    logic [RS_ADDR_WIDTH-1:0] a;
    a = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      a = a | ({RS_ADDR_WIDTH{oh[i]}} & RS_ADDR_WIDTH'(i));
    end
    return a;
  endfunction

  function automatic logic [RS_DEPTH-1:0] addr_oh(input logic [RS_ADDR_WIDTH-1:0] a);
    return {{(RS_DEPTH-1){1'b0}}, 1'b1} << a;
  endfunction

  function automatic logic [RS_ADDR_WIDTH:0] popcount(input logic [RS_DEPTH-1:0] v);
    logic [RS_ADDR_WIDTH:0] c;
    c = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      c = c + {{RS_ADDR_WIDTH{1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [RS_DEPTH-1:0]               pending_q, pending_d;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;
  logic                              p0_valid_q, p0_valid_d;
  logic [RS_ADDR_WIDTH-1:0]          p0_addr_q, p0_addr_d;
  logic [RS_ADDR_WIDTH:0]            cnt_q, cnt_d;

  logic [RS_DEPTH-1:0]      held_s;
  logic [RS_DEPTH-1:0]      elig_s;
  logic [RS_DEPTH-1:0]      sel0_oh_s;
  logic [RS_ADDR_WIDTH-1:0] sel0_addr_s;
  logic [RS_DEPTH-1:0]      load_mask_s;
  logic                     p0_free_s;

  assign elig_s      = pending_q & rs_ready;
  assign sel0_oh_s   = oldest_oh(elig_s, older_q);
  assign sel0_addr_s = oh_encode(sel0_oh_s);
  assign p0_free_s   = ~p0_valid_q | issue0_ready;

`ifdef QU_ISSUE_SCHED_DUAL_EN
  logic                     p1_valid_q, p1_valid_d;
  logic [RS_ADDR_WIDTH-1:0] p1_addr_q, p1_addr_d;
  logic [RS_DEPTH-1:0]      sel1_oh_s;
  logic [RS_ADDR_WIDTH-1:0] sel1_addr_s;
  logic                     p1_free_s;

  assign sel1_oh_s   = oldest_oh(elig_s & ~sel0_oh_s, older_q);
  assign sel1_addr_s = oh_encode(sel1_oh_s);
  assign p1_free_s   = ~p1_valid_q | issue1_ready;
  assign held_s      = (addr_oh(p0_addr_q) & {RS_DEPTH{p0_valid_q}})
                     | (addr_oh(p1_addr_q) & {RS_DEPTH{p1_valid_q}});

  // Port load: both free takes the two oldest, a single free port takes the oldest.
  always_comb begin
    p0_valid_d  = p0_valid_q;
    p0_addr_d   = p0_addr_q;
    p1_valid_d  = p1_valid_q;
    p1_addr_d   = p1_addr_q;
    load_mask_s = '0;
    if (flush) begin
      p0_valid_d = 1'b0;
      p1_valid_d = 1'b0;
    end else if (stall) begin
      // Accepted entries still leave; nothing new is loaded.
      p0_valid_d = p0_valid_q & ~p0_free_s;
      p1_valid_d = p1_valid_q & ~p1_free_s;
    end else if (p0_free_s && p1_free_s) begin
      p0_valid_d  = |sel0_oh_s;
      p0_addr_d   = sel0_addr_s;
      p1_valid_d  = |sel1_oh_s;
      p1_addr_d   = sel1_addr_s;
      load_mask_s = sel0_oh_s | sel1_oh_s;
    end else if (p0_free_s) begin
      p0_valid_d  = |sel0_oh_s;
      p0_addr_d   = sel0_addr_s;
      load_mask_s = sel0_oh_s;
    end else if (p1_free_s) begin
      p1_valid_d  = |sel0_oh_s;
      p1_addr_d   = sel0_addr_s;
      load_mask_s = sel0_oh_s;
    end else begin
      load_mask_s = '0;
    end
  end

  // Port 1 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid_q <= 1'b0;
      p1_addr_q  <= '0;
    end else begin
      p1_valid_q <= p1_valid_d;
      p1_addr_q  <= p1_addr_d;
    end
  end

  assign issue1_valid = p1_valid_q;
  assign issue1_addr  = p1_addr_q;
  assign free1_en     = p1_valid_q & issue1_ready & ~flush;
  assign free1_addr   = p1_addr_q;
`else
  logic unused_issue1_ready_s;

  assign unused_issue1_ready_s = issue1_ready;
  assign held_s = addr_oh(p0_addr_q) & {RS_DEPTH{p0_valid_q}};

  // Port load: the single port takes the oldest eligible entry when free.
  always_comb begin
    p0_valid_d  = p0_valid_q;
    p0_addr_d   = p0_addr_q;
    load_mask_s = '0;
    if (flush) begin
      p0_valid_d = 1'b0;
    end else if (stall) begin
      p0_valid_d = p0_valid_q & ~p0_free_s;
    end else if (p0_free_s) begin
      p0_valid_d  = |sel0_oh_s;
      p0_addr_d   = sel0_addr_s;
      load_mask_s = sel0_oh_s;
    end else begin
      load_mask_s = '0;
    end
  end

  assign issue1_valid = 1'b0;
  assign issue1_addr  = '0;
  assign free1_en     = 1'b0;
  assign free1_addr   = '0;
`endif

  // Pending set and age matrix update; flush drops a simultaneous allocation.
  always_comb begin
    pending_d = pending_q & ~load_mask_s;
    older_d   = older_q;
    if (flush) begin
      pending_d = '0;
    end else if (alloc_en) begin
      pending_d[alloc_addr] = 1'b1;
      // Everything still live is older than the new entry; it is older than nobody.
      older_d[alloc_addr] = pending_q | held_s;
      for (int j = 0; j < RS_DEPTH; j++) begin
        older_d[j][alloc_addr] = 1'b0;
      end
    end else begin
      older_d = older_q;
    end
    cnt_d = popcount(pending_d);
  end

  // Core state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      older_q    <= '0;
      p0_valid_q <= 1'b0;
      p0_addr_q  <= '0;
      cnt_q      <= '0;
    end else begin
      pending_q  <= pending_d;
      older_q    <= older_d;
      p0_valid_q <= p0_valid_d;
      p0_addr_q  <= p0_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign issue0_valid = p0_valid_q;
  assign issue0_addr  = p0_addr_q;
  assign free0_en     = p0_valid_q & issue0_ready & ~flush;
  assign free0_addr   = p0_addr_q;
  assign pending_cnt  = cnt_q;

  qu_issue_sched_chk #(
    .RS_DEPTH      (RS_DEPTH),
    .RS_ADDR_WIDTH (RS_ADDR_WIDTH)
  ) u_chk (
    .clk_i        (clk),
    .rst_i        (rst),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .pending_i    (pending_q),
    .held_i       (held_s)
  );

endmodule

// File: tb/tb_qu_issue_sched.sv
module tb_qu_issue_sched;

`ifdef QU_ISSUE_SCHED_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0, stall = 1'b0, alloc_en = 1'b0;
  logic [3:0]  alloc_addr = 4'd0;
  logic [15:0] rs_ready = 16'd0;
  logic        issue0_ready = 1'b0, issue1_ready = 1'b0;
  logic        issue0_valid, issue1_valid, free0_en, free1_en;
  logic [3:0]  issue0_addr, issue1_addr, free0_addr, free1_addr;
  logic [4:0]  pending_cnt;

  qu_issue_sched #(.RS_DEPTH(16), .RS_ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .rs_ready(rs_ready),
    .issue0_valid(issue0_valid), .issue0_addr(issue0_addr), .issue0_ready(issue0_ready),
    .issue1_valid(issue1_valid), .issue1_addr(issue1_addr), .issue1_ready(issue1_ready),
    .free0_en(free0_en), .free0_addr(free0_addr),
    .free1_en(free1_en), .free1_addr(free1_addr),
    .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: pending entries kept in allocation order, plus the two ports.
  int q[$];
  bit m_v0 = 1'b0, m_v1 = 1'b0;
  int m_a0 = 0, m_a1 = 0;

  typedef struct packed {
    logic        f, s, ae;
    logic [3:0]  aa;
    logic [15:0] rr;
    logic        r0, r1;
    logic        ev0;
    logic [3:0]  ea0;
    logic        ev1;
    logic [3:0]  ea1;
    logic [4:0]  ecnt;
    logic        ef0;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic f, logic s, logic ae, logic [3:0] aa, logic [15:0] rr,
                              logic r0, logic r1, logic ev0, logic [3:0] ea0, logic ev1,
                              logic [3:0] ea1, logic [4:0] ecnt, logic ef0);
    vec_t v;
    v.f = f; v.s = s; v.ae = ae; v.aa = aa; v.rr = rr; v.r0 = r0; v.r1 = r1;
    v.ev0 = ev0; v.ea0 = ea0; v.ev1 = ev1; v.ea1 = ea1; v.ecnt = ecnt; v.ef0 = ef0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic qremove(input int a);
    for (int k = 0; k < q.size(); k++) begin
      if (q[k] == a) begin
        q.delete(k);
        break;
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int el[$];
    bit fr0, fr1;
    if (flush) begin
      q.delete();
      m_v0 = 1'b0;
      m_v1 = 1'b0;
    end else begin
      fr0 = !m_v0 || issue0_ready;
      fr1 = DUAL && (!m_v1 || issue1_ready);
      foreach (q[k]) if (rs_ready[q[k]]) el.push_back(q[k]);
      if (stall) begin
        if (fr0) m_v0 = 1'b0;
        if (fr1) m_v1 = 1'b0;
      end else if (fr0 && fr1) begin
        m_v0 = el.size() > 0;
        if (m_v0) begin m_a0 = el[0]; qremove(el[0]); end
        m_v1 = el.size() > 1;
        if (m_v1) begin m_a1 = el[1]; qremove(el[1]); end
      end else if (fr0) begin
        m_v0 = el.size() > 0;
        if (m_v0) begin m_a0 = el[0]; qremove(el[0]); end
      end else if (fr1) begin
        m_v1 = el.size() > 0;
        if (m_v1) begin m_a1 = el[0]; qremove(el[0]); end
      end
      if (alloc_en) q.push_back(int'(alloc_addr));
    end
  endtask

  task automatic check_model();
    bit ef0, ef1;
    ef0 = m_v0 && issue0_ready && !flush;
    ef1 = m_v1 && issue1_ready && !flush;
    chk("issue0_valid", issue0_valid, m_v0);
    if (m_v0) chk("issue0_addr", issue0_addr, m_a0);
    chk("issue1_valid", issue1_valid, m_v1);
    if (m_v1) chk("issue1_addr", issue1_addr, m_a1);
    chk("pending_cnt", pending_cnt, q.size());
    chk("free0_en", free0_en, ef0);
    if (ef0) chk("free0_addr", free0_addr, m_a0);
    chk("free1_en", free1_en, ef1);
    if (ef1) chk("free1_addr", free1_addr, m_a1);
  endtask

  task automatic apply(input logic f, input logic s, input logic ae, input logic [3:0] aa,
                       input logic [15:0] rr, input logic r0, input logic r1);
    flush = f; stall = s; alloc_en = ae; alloc_addr = aa;
    rs_ready = rr; issue0_ready = r0; issue1_ready = r1;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic f, input logic s, input logic ae, input logic [3:0] aa,
                     input logic [15:0] rr, input logic r0, input logic r1);
    apply(f, s, ae, aa, rr, r0, r1);
    check_model();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl[$];
    logic ae, f, s;
    logic [3:0] aa;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_issue0_valid", issue0_valid, 1'b0);
    chk("rst_issue1_valid", issue1_valid, 1'b0);
    chk("rst_issue0_addr", issue0_addr, 4'd0);
    chk("rst_pending_cnt", pending_cnt, 5'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Age ordering followed by flush-drops-allocation, as fixed vectors.
    tbl.push_back(mk(0, 0, 1, 4'd5, 16'h0000, 1, 1, 0, 0, 0, 0, 5'd0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd2, 16'h0000, 1, 1, 0, 0, 0, 0, 5'd1, 0));
    tbl.push_back(mk(0, 0, 1, 4'd9, 16'h0000, 1, 1, 0, 0, 0, 0, 5'd2, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 16'hFFFF, 1, 1, 0, 0, 0, 0, 5'd3, 0));
`ifdef QU_ISSUE_SCHED_DUAL_EN
    tbl.push_back(mk(0, 0, 0, 4'd0, 16'hFFFF, 1, 1, 1, 4'd5, 1, 4'd2, 5'd1, 1));
    tbl.push_back(mk(0, 0, 0, 4'd0, 16'hFFFF, 1, 1, 1, 4'd9, 0, 4'd0, 5'd0, 1));
    tbl.push_back(mk(0, 0, 0, 4'd0, 16'hFFFF, 1, 1, 0, 4'd0, 0, 4'd0, 5'd0, 0));
`else
    tbl.push_back(mk(0, 0, 0, 4'd0, 16'hFFFF, 1, 1, 1, 4'd5, 0, 4'd0, 5'd2, 1));
    tbl.push_back(mk(0, 0, 0, 4'd0, 16'hFFFF, 1, 1, 1, 4'd2, 0, 4'd0, 5'd1, 1));
    tbl.push_back(mk(0, 0, 0, 4'd0, 16'hFFFF, 1, 1, 1, 4'd9, 0, 4'd0, 5'd0, 1));
`endif
    tbl.push_back(mk(0, 0, 0, 4'd0, 16'hFFFF, 1, 1, 0, 4'd0, 0, 4'd0, 5'd0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd10, 16'h0000, 1, 1, 0, 0, 0, 0, 5'd0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd11, 16'h0000, 1, 1, 0, 0, 0, 0, 5'd1, 0));
    tbl.push_back(mk(0, 0, 1, 4'd12, 16'h0000, 1, 1, 0, 0, 0, 0, 5'd2, 0));
    tbl.push_back(mk(1, 0, 1, 4'd1, 16'hFFFF, 1, 1, 0, 0, 0, 0, 5'd3, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 16'hFFFF, 1, 1, 0, 0, 0, 0, 5'd0, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 16'hFFFF, 1, 1, 0, 0, 0, 0, 5'd0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].f, tbl[i].s, tbl[i].ae, tbl[i].aa, tbl[i].rr, tbl[i].r0, tbl[i].r1);
      chk("tbl_issue0_valid", issue0_valid, tbl[i].ev0);
      if (tbl[i].ev0) chk("tbl_issue0_addr", issue0_addr, tbl[i].ea0);
      chk("tbl_issue1_valid", issue1_valid, tbl[i].ev1);
      if (tbl[i].ev1) chk("tbl_issue1_addr", issue1_addr, tbl[i].ea1);
      chk("tbl_pending_cnt", pending_cnt, tbl[i].ecnt);
      chk("tbl_free0_en", free0_en, tbl[i].ef0);
      check_model();
      tick();
    end

    // Wake-up bypasses age: 7 issues before the older 3.
    cyc(1, 0, 0, 4'd0, 16'h0000, 0, 0);
    cyc(0, 0, 1, 4'd3, 16'h0000, 1, 1);
    cyc(0, 0, 1, 4'd7, 16'h0000, 1, 1);
    cyc(0, 0, 0, 4'd0, 16'h0080, 1, 1);
    chk("wake_v0_7", issue0_valid, 1'b1);
    chk("wake_a0_7", issue0_addr, 4'd7);
    cyc(0, 0, 0, 4'd0, 16'h0080, 1, 1);
    cyc(0, 0, 0, 4'd0, 16'h0080, 1, 1);
    cyc(0, 0, 0, 4'd0, 16'h0088, 1, 1);
    chk("wake_v0_3", issue0_valid, 1'b1);
    chk("wake_a0_3", issue0_addr, 4'd3);
    cyc(0, 0, 0, 4'd0, 16'h0088, 1, 1);

    // Back-pressure on port 0 while 6 and 8 are eligible.
    cyc(1, 0, 0, 4'd0, 16'h0000, 0, 0);
    cyc(0, 0, 1, 4'd4, 16'h0000, 0, 1);
    cyc(0, 0, 1, 4'd6, 16'h0000, 0, 1);
    cyc(0, 0, 1, 4'd8, 16'h0000, 0, 1);
    cyc(0, 0, 0, 4'd0, 16'h0010, 0, 1);
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 0, 4'd0, 16'h0150, 0, 1);
      chk("bp_hold_v0", issue0_valid, 1'b1);
      chk("bp_hold_a0", issue0_addr, 4'd4);
      chk("bp_hold_free0", free0_en, 1'b0);
      check_model();
      tick();
    end
    apply(0, 0, 0, 4'd0, 16'h0150, 1, 1);
    chk("bp_release_free0", free0_en, 1'b1);
    chk("bp_release_addr", free0_addr, 4'd4);
    check_model();
    tick();
    apply(0, 0, 0, 4'd0, 16'h0150, 0, 1);
    chk("bp_after_free0", free0_en, 1'b0);
    check_model();
    tick();

    // Stall holds off selection of two eligible entries.
    cyc(1, 0, 0, 4'd0, 16'h0000, 0, 0);
    cyc(0, 1, 1, 4'd10, 16'hFFFF, 1, 1);
    cyc(0, 1, 1, 4'd11, 16'hFFFF, 1, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 4'd0, 16'hFFFF, 1, 1);
      chk("stall_v0", issue0_valid, 1'b0);
      chk("stall_v1", issue1_valid, 1'b0);
    end
    cyc(0, 0, 0, 4'd0, 16'hFFFF, 0, 0);
    chk("unstall_v0", issue0_valid, 1'b1);
    chk("unstall_a0", issue0_addr, 4'd10);

    // Asynchronous reset with ports loaded.
    cyc(1, 0, 0, 4'd0, 16'h0000, 0, 0);
    cyc(0, 0, 1, 4'd1, 16'hFFFF, 0, 0);
    cyc(0, 0, 1, 4'd2, 16'hFFFF, 0, 0);
    cyc(0, 0, 0, 4'd0, 16'hFFFF, 0, 0);
    chk("prerst_v0", issue0_valid, 1'b1);
    apply(0, 0, 0, 4'd0, 16'hFFFF, 1, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_issue0_valid", issue0_valid, 1'b0);
    chk("arst_issue0_addr", issue0_addr, 4'd0);
    chk("arst_issue1_valid", issue1_valid, 1'b0);
    chk("arst_issue1_addr", issue1_addr, 4'd0);
    chk("arst_free0_en", free0_en, 1'b0);
    chk("arst_free1_en", free1_en, 1'b0);
    chk("arst_pending_cnt", pending_cnt, 5'd0);
    q.delete();
    m_v0 = 1'b0;
    m_v1 = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      fl.delete();
      for (int a = 0; a < 16; a++) begin
        bit busy;
        busy = (m_v0 && m_a0 == a) || (m_v1 && m_a1 == a);
        foreach (q[k]) if (q[k] == a) busy = 1'b1;
        if (!busy) fl.push_back(a);
      end
      ae = (fl.size() > 0) && ($urandom_range(0, 1) == 1);
      aa = ae ? 4'(fl[$urandom_range(0, fl.size() - 1)]) : 4'd0;
      f  = ($urandom_range(0, 29) == 0);
      s  = ($urandom_range(0, 9) == 0);
      cyc(f, s, ae, aa, 16'($urandom) | 16'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
